// File: rtl/fmap_pingpong_ram_if.sv
// Producer/consumer bus of the ping-pong feature-map buffer.
// master = the two adjacent layers, slave = the buffer itself.
interface fmap_pingpong_ram_if #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 7
);
    // producer side
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] d_in;
    logic              wr_done;
    logic              wr_ready;

    // consumer side
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_done;
    logic              rd_ready;
    logic [DATA_W-1:0] d_out;
    logic              d_valid;

    // status
    logic [1:0]        level;
    logic              err;

    modport master (
        output wr_en,
        output wr_addr,
        output d_in,
        output wr_done,
        output rd_en,
        output rd_addr,
        output rd_done,
        input  wr_ready,
        input  rd_ready,
        input  d_out,
        input  d_valid,
        input  level,
        input  err
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  d_in,
        input  wr_done,
        input  rd_en,
        input  rd_addr,
        input  rd_done,
        output wr_ready,
        output rd_ready,
        output d_out,
        output d_valid,
        output level,
        output err
    );
endinterface

// File: rtl/fmap_pingpong_ram.sv
// Double-buffered feature-map RAM: producer fills one bank while the consumer
// drains the other; banks change hands on explicit wr_done/rd_done pulses.
module fmap_pingpong_ram #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 7
) (
    input  logic               clk,
    input  logic               rst,
    fmap_pingpong_ram_if.slave bus
);
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    // control state
    logic       wr_bank_reg, wr_bank_next;
    logic       rd_bank_reg, rd_bank_next;
    logic [1:0] full_reg, full_next;
    logic       err_reg, err_next;
    logic       d_valid_reg, d_valid_next;
    logic       rd_sel_reg;

    // decoded handshake terms
    logic             wr_ready;
    logic             rd_ready;
    logic             wr_addr_ok;
    logic             rd_addr_ok;
    logic             wr_accept;
    logic             rd_accept;
    logic             wr_swap;
    logic             rd_swap;
    logic             proto_err;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    logic [DATA_W-1:0] bank_q [2];

    assign wr_ready = !full_reg[wr_bank_reg];
    assign rd_ready = full_reg[rd_bank_reg];
    assign wr_idx   = bus.wr_addr[IDX_W-1:0];
    assign rd_idx   = bus.rd_addr[IDX_W-1:0];

    always_comb begin
        wr_addr_ok = ({1'b0, bus.wr_addr} < DEPTH_L);
        rd_addr_ok = ({1'b0, bus.rd_addr} < DEPTH_L);
        wr_accept  = bus.wr_en && wr_ready && wr_addr_ok;
        rd_accept  = bus.rd_en && rd_ready && rd_addr_ok;
        wr_swap    = bus.wr_done && wr_ready;
        rd_swap    = bus.rd_done && rd_ready;
        proto_err  = (bus.wr_en   && !wr_accept) ||
                     (bus.wr_done && !wr_ready)  ||
                     (bus.rd_en   && !rd_accept) ||
                     (bus.rd_done && !rd_ready);
    end

    // A legal wr_done targets an empty bank and a legal rd_done a full one,
    // so the two swaps can never touch the same full bit.
    always_comb begin
        wr_bank_next = wr_bank_reg;
        rd_bank_next = rd_bank_reg;
        full_next    = full_reg;
        err_next     = err_reg | proto_err;
        d_valid_next = rd_accept;

        if (wr_swap) begin
            full_next[wr_bank_reg] = 1'b1;
            wr_bank_next           = !wr_bank_reg;
        end
        if (rd_swap) begin
            full_next[rd_bank_reg] = 1'b0;
            rd_bank_next           = !rd_bank_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_bank_reg <= 1'b0;
            rd_bank_reg <= 1'b0;
            full_reg    <= 2'b00;
            err_reg     <= 1'b0;
            d_valid_reg <= 1'b0;
        end else begin
            wr_bank_reg <= wr_bank_next;
            rd_bank_reg <= rd_bank_next;
            full_reg    <= full_next;
            err_reg     <= err_next;
            d_valid_reg <= d_valid_next;
        end
    end

    // Remembers which bank's output register holds the word being returned.
    always_ff @(posedge clk) begin
        if (rd_accept) begin
            rd_sel_reg <= rd_bank_reg;
        end
    end

    // One inferred RAM per bank; contents survive reset on purpose.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [DATA_W-1:0] mem [DEPTH];
            logic [DATA_W-1:0] q_reg;

            always_ff @(posedge clk) begin
                if (wr_accept && (wr_bank_reg == 1'(gi))) begin
                    mem[wr_idx] <= bus.d_in;
                end
                if (rd_accept && (rd_bank_reg == 1'(gi))) begin
                    q_reg <= mem[rd_idx];
                end
            end

            assign bank_q[gi] = q_reg;
        end
    endgenerate

    // Returned data is forced to zero whenever the previous cycle had no accepted read.
    assign bus.d_out    = d_valid_reg ? bank_q[rd_sel_reg] : '0;
    assign bus.d_valid  = d_valid_reg;
    assign bus.wr_ready = wr_ready;
    assign bus.rd_ready = rd_ready;
    assign bus.level    = {1'b0, full_reg[0]} + {1'b0, full_reg[1]};
    assign bus.err      = err_reg;
endmodule
